hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard/forwarding unit for the in-order decode/issue pipeline, replacing fixed match-bit hazard logic with an internal per-register scoreboard. It sits at the decode→execute boundary, compares source/destination register addresses internally, and tracks in-flight results of variable latency (ALU, multiply, load). It produces stall, forward-select and stall-cause outputs for any ISA front end.

## Interface
- NREG, 16, number of architectural registers tracked
- AW, 4, register address width; NREG ≤ 2**AW
- NSRC, 3, source operand ports checked per instruction
- MAXLAT, 7, maximum result latency in cycles (≥1)
- LATW, 3, latency field width; 2**LATW > MAXLAT
- ZERO_REG, 1, when 1 register 0 is hardwired zero: never reserved, never hazards
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- issue_valid  in  1  an instruction is present in decode
- flush  in  1  cancel the decode instruction this cycle
- src_addr  in  NSRC*AW  source addresses, port i at bits [i*AW +: AW]
- src_valid  in  NSRC  source port i is read
- dst_addr  in  AW  destination register
- dst_valid  in  1  instruction writes dst_addr
- lat  in  LATW  cycles until the result appears on the writeback bus
- stall  out  1  stall_raw | stall_waw | stall_wb
- stall_raw  out  1  a valid source is not yet forwardable
- stall_waw  out  1  older write to dst_addr would complete after the new one
- stall_wb  out  1  writeback slot already reserved
- fwd_sel  out  NSRC  1 = take port i from the writeback bus
- issue_fire  out  1  instruction accepted this cycle
- busy_any  out  1  any counter nonzero

## Operation
- State: cnt[r] (LATW bits) per register; slot vector S[MAXLAT:1], S[k]=1 iff some in-flight result has counter value k.
- cnt==0: value in register file. cnt==1: value on writeback bus this cycle. cnt≥2: unavailable.
- Effective latency L = lat clamped to [1, MAXLAT] (0→1, >MAXLAT→MAXLAT).
- Tracked dst: dst_valid && !(ZERO_REG && dst_addr==0). Hazarding src: src_valid[i] && !(ZERO_REG && src_addr_i==0).
- All hazard outputs gated by issue_valid; all zero when issue_valid=0.
- stall_raw: any hazarding src with cnt[src]≥2.
- fwd_sel[i]: hazarding src with cnt[src]==1; independent of stall.
- stall_waw: tracked dst with cnt[dst_addr] > L.
- stall_wb: tracked dst, L<MAXLAT, S[L+1]==1.
- issue_fire = issue_valid && !stall && !flush. flush never asserts stall.
- Per posedge: cnt[r] ← L if issue_fire && tracked dst==r, else max(cnt[r]-1, 0). S[k] ← S[k+1] | (issue_fire && tracked dst && L==k), with S[MAXLAT+1]≡0.
- Untracked or flushed instructions change no state; counters still decrement.
- Guarantee: at most one result per cycle on writeback; in-order completion per register.

## Timing
- Outputs combinational from inputs and registered state; no input-to-state latency beyond one edge.
- Reset (async, low): all cnt=0, S=0 immediately; stall, causes, fwd_sel, busy_any = 0; issue_fire = issue_valid && !flush.
- Reset mid-operation discards all reservations same cycle; no stall after release.
- Consumer of latency-L producer issued at cycle t: stalls t+1..t+L-1, fires at t+L with fwd_sel=1; no stall for L=1.
- Same-cycle fire writing and reading one register: source checked against old cnt.

## Test plan
- Reset: hold reset low 2 cycles, random inputs → stall=0, fwd_sel=0, busy_any=0; release → identical.
- RAW: fire dst=5 lat=3 at t; at t+1 src0=5 → stall_raw=1 at t+1, t+2; at t+3 stall=0, fwd_sel=3'b001, issue_fire=1; busy_any=0 at t+4.
- Writeback conflict: fire dst=1 lat=3 at t; at t+1 dst=2 lat=2 → stall_wb=1; t+2 fires; results complete at t+3 and t+4 (one per cycle).
- WAW: fire dst=4 lat=6 at t; dst=4 lat=1 from t+1 → stall_waw for 5 cycles (t+1..t+5), fires t+6.
- ZERO_REG/flush: dst=0 lat=5 fires → busy_any=0, later src=0 no stall; dst=7 lat=4 with flush=1 → issue_fire=0, cnt[7] stays 0.
- Clamp: lat=0 with dst=3 → behaves as L=1; mid-stall assert reset → all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Decode/issue hazard and forwarding unit for an in-order pipeline.
//   Each architectural register carries a small countdown of the cycles left
//   until its pending result reaches the writeback bus:
//     0  -> the value is in the register file
//     1  -> the value is on the writeback bus this cycle and can be forwarded
//     >=2 -> the value is not available yet
//   A slot vector records which future writeback cycles are already claimed.
//   The unit uses it to put at most one result on the bus per cycle.
//   All outputs are combinational from the decode inputs and the registered
//   scoreboard state.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG     = 16,
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int MAXLAT   = 7,
  parameter int LATW     = 3,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               flush,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [AW-1:0]      dst_addr,
  input  logic               dst_valid,
  input  logic [LATW-1:0]    lat,
  output logic               stall,
  output logic               stall_raw,
  output logic               stall_waw,
  output logic               stall_wb,
  output logic [NSRC-1:0]    fwd_sel,
  output logic               issue_fire,
  output logic               busy_any
);

  // Clamp a requested latency into the supported range [1, MAXLAT].
  function automatic logic [LATW-1:0] clamp_lat(input logic [LATW-1:0] l);
    logic [LATW-1:0] r;
    if (l == {LATW{1'b0}}) begin
      r = LATW'(1);
    end else if (int'(l) > MAXLAT) begin
      r = LATW'(MAXLAT);
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Register 0 is excluded from tracking when it is hardwired to zero.
  // Addresses beyond NREG have no counter and are never tracked.
  function automatic logic addr_tracked(input logic [AW-1:0] a);
    logic r;
    if ((ZERO_REG != 0) && (a == {AW{1'b0}})) begin
      r = 1'b0;
    end else if (int'(a) >= NREG) begin
      r = 1'b0;
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard state.
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];
  logic [MAXLAT:1] slot_q;
  logic [MAXLAT:1] slot_d;

  // Decode-side intermediate signals.
  logic [LATW-1:0] lat_eff_s;
  logic            dst_tracked_s;
  logic [LATW-1:0] dst_cnt_s;
  logic [LATW-1:0] src_cnt_s [NSRC];
  logic [NSRC-1:0] src_hz_s;
  logic [NSRC-1:0] raw_vec_s;
  logic            wb_hit_s;
  logic            raw_s;
  logic            waw_s;
  logic            wb_s;
  logic            stall_s;
  logic            fire_s;
  logic            write_s;

  // Effective latency and whether the destination needs a reservation.
  always_comb begin
    lat_eff_s     = clamp_lat(lat);
    dst_tracked_s = dst_valid & addr_tracked(dst_addr);
  end

  // Look up the current countdown for each source port and for the destination.
  always_comb begin
    dst_cnt_s = {LATW{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      dst_cnt_s = dst_cnt_s | ((dst_addr == AW'(r)) ? cnt_q[r] : {LATW{1'b0}});
    end
    for (int i = 0; i < NSRC; i++) begin
      src_cnt_s[i] = {LATW{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        src_cnt_s[i] = src_cnt_s[i] |
                       ((src_addr[i*AW +: AW] == AW'(r)) ? cnt_q[r] : {LATW{1'b0}});
      end
      src_hz_s[i] = src_valid[i] & addr_tracked(src_addr[i*AW +: AW]);
    end
  end

  // Per-source RAW detection and forward selection. A source at countdown 1
  // is on the writeback bus now, so it forwards rather than stalls.
  always_comb begin
    raw_vec_s = {NSRC{1'b0}};
    fwd_sel   = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      raw_vec_s[i] = issue_valid & src_hz_s[i] & (src_cnt_s[i] >= LATW'(2));
      fwd_sel[i]   = issue_valid & src_hz_s[i] & (src_cnt_s[i] == LATW'(1));
    end
  end

  // Writeback-slot conflict: the new result would land in the same cycle as
  // an in-flight one. The slot is checked one position up because the vector
  // shifts down on the edge where the instruction issues.
  always_comb begin
    wb_hit_s = 1'b0;
    for (int k = 1; k < MAXLAT; k++) begin
      wb_hit_s = wb_hit_s | ((lat_eff_s == LATW'(k)) & slot_q[k+1]);
    end
  end

  // Stall causes, issue acceptance and busy summary. Flush only blocks the
  // fire; it never raises a stall.
  always_comb begin
    raw_s   = |raw_vec_s;
    waw_s   = issue_valid & dst_tracked_s & (dst_cnt_s > lat_eff_s);
    wb_s    = issue_valid & dst_tracked_s & wb_hit_s;
    stall_s = raw_s | waw_s | wb_s;
    fire_s  = issue_valid & ~stall_s & ~flush;
    write_s = fire_s & dst_tracked_s;

    stall_raw  = raw_s;
    stall_waw  = waw_s;
    stall_wb   = wb_s;
    stall      = stall_s;
    issue_fire = fire_s;

    busy_any = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      busy_any = busy_any | (cnt_q[r] != {LATW{1'b0}});
    end
  end

  // Next-state countdowns: reload on an accepted write, otherwise count to 0.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (write_s && (dst_addr == AW'(r))) begin
        cnt_d[r] = lat_eff_s;
      end else if (cnt_q[r] != {LATW{1'b0}}) begin
        cnt_d[r] = cnt_q[r] - LATW'(1);
      end else begin
        cnt_d[r] = {LATW{1'b0}};
      end
    end
  end

  // Next-state slot vector: shift toward the bus and claim the new slot.
  always_comb begin
    slot_d = {MAXLAT{1'b0}};
    for (int k = 1; k <= MAXLAT; k++) begin
      if (k < MAXLAT) begin
        slot_d[k] = slot_q[k+1] | (write_s & (lat_eff_s == LATW'(k)));
      end else begin
        slot_d[k] = write_s & (lat_eff_s == LATW'(k));
      end
    end
  end

  // Scoreboard registers; reset drops every reservation immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= {LATW{1'b0}};
      end
      slot_q <= {MAXLAT{1'b0}};
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      slot_q <= slot_d;
    end
  end

endmodule
